idma_reg64_launcher: RTL
========================

Name: idma_reg64_launcher

Overview:
Register-interface initiator that programs and launches transfers on the 64-bit iDMA register frontend, then tracks their completion. It accepts one job descriptor at a time over a valid/ready port. It writes the source, destination, length and configuration registers, then reads NEXT_ID to launch the transfer. It polls DONE until the returned transfer ID has retired and reports the result on a completion port. It sits between a job source (sequencer, test harness or local controller) and the DMA's register control slave.

Parameters:
reg_req_t, logic, register_interface request type (fields: valid, write, addr, wdata, wstrb)
reg_rsp_t, logic, register_interface response type (fields: ready, rdata, error)
AddrWidth, 32, reg_req_t.addr width
BaseAddr, 0, DMA register block base address
SrcAddrOffset, 'h00, source address register offset
DstAddrOffset, 'h08, destination address register offset
NumBytesOffset, 'h10, length register offset
ConfOffset, 'h18, conf register offset (bit0 decouple, bit1 deburst)
NextIdOffset, 'h28, next_id register offset (read launches)
DoneOffset, 'h30, done register offset
PollGap, 4, idle cycles between DONE polls (0 allowed)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  launcher idle, accepts job
job_src_i  in  64  source address
job_dst_i  in  64  destination address
job_len_i  in  64  byte count
job_decouple_i  in  1  conf.decouple
job_deburst_i  in  1  conf.deburst
reg_req_o  out  reg_req_t  register request to DMA control slave
reg_rsp_i  in  reg_rsp_t  register response
cpl_valid_o  out  1  completion valid
cpl_ready_i  in  1  completion accepted
cpl_id_o  out  64  transfer ID assigned by DMA
cpl_error_o  out  1  job failed (zero length or bus error)
busy_o  out  1  state != IDLE

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low; all state registered.
- Reset: state IDLE, reg_req_o all-zero, job_ready_o=1, cpl_valid_o=0, cpl_id_o=0, cpl_error_o=0, busy_o=0, poll counter 0.
- Job capture: on job_valid_i && job_ready_o, latch the descriptor and go to WR_SRC. job_ready_o is 1 only in IDLE.
- Zero length: job_len_i==0 goes straight to CPL with cpl_error_o=1, cpl_id_o=0 and no bus access. The DMA would refuse the launch.
- Bus handshake:
  - A beat completes when reg_req_o.valid && reg_rsp_i.ready.
  - addr, write, wdata and wstrb stay stable while valid is high and ready is low.
  - Writes use wstrb all-ones and a 64-bit wdata.
  - Each state holds until its beat completes; valid is registered, so the first beat of each state is issued on the cycle after the state is entered.
- States:
  - WR_SRC: write src to BaseAddr+SrcAddrOffset.
  - WR_DST: write dst.
  - WR_LEN: write length.
  - WR_CONF: write {62'b0, deburst, decouple}.
  - RD_NEXT: read NextIdOffset. The DMA holds ready low until its backend accepts the burst. On completion, latch rdata as id_q.
  - WAIT: count PollGap cycles.
  - RD_DONE: read DoneOffset. If (rdata - id_q) has MSB==0, the transfer has retired (wrap-safe 64-bit compare): go to CPL. Otherwise go to WAIT.
  - CPL: assert cpl_valid_o with cpl_id_o=id_q and cpl_error_o=0. Hold until cpl_ready_i, then return to IDLE.
- Error: reg_rsp_i.error=1 on any completing beat aborts the job. Go to CPL with cpl_error_o=1, cpl_id_o=id_q (0 if NEXT_ID not yet read).
- A NEXT_ID read that returns 0 with no error is treated as a rejected launch: go to CPL with error=1.
- PollGap=0: RD_DONE re-issues back-to-back with the deassert cycle skipped.
- Reset mid-operation returns to IDLE immediately. Any in-flight reg beat is abandoned; valid drops asynchronously with reset.
- Only one job is outstanding; no pipelining of descriptors.

Test Plan:
- Basic job: src=0x1000, dst=0x2000, len=0x40, decouple=1, deburst=0; slave ready in 1 cycle, NEXT_ID returns 5, DONE returns 4 then 5 -> writes in order 0x00/0x08/0x10/0x18 with conf wdata=0x1, two DONE reads spaced by 4 idle cycles, cpl_id_o=5, cpl_error_o=0.
- Backpressure: slave ready low 10 cycles on WR_DST and 20 cycles on RD_NEXT -> reg_req_o fields constant throughout, no duplicate beats.
- Zero length: len=0 -> no reg_req_o.valid ever, cpl_valid_o the cycle after acceptance, error=1, id=0.
- Bus error on WR_LEN -> no WR_CONF or NEXT_ID access, cpl error=1, id=0.
- Wrap: NEXT_ID=0xFFFF_FFFF_FFFF_FFFF, DONE returns 0xFFFF_FFFF_FFFF_FFFE then 0x0 -> first poll not done, second poll completes.
- Reset asserted during RD_DONE poll, and cpl_ready_i held low 5 cycles on a later job -> after reset all outputs return to reset values; cpl fields held stable during the stall, next job accepted only after the handshake.

Source files
------------

// File: rtl/idma_reg64_launcher.sv
// Register-interface initiator for the 64-bit iDMA frontend: programs one job, launches it by
// reading NEXT_ID, polls DONE until the returned ID retires, then reports on a completion port.
package idma_reg64_launcher_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] rdata;
    logic        error;
  } reg_rsp_t;
endpackage

module idma_reg64_launcher #(
  parameter int unsigned          AddrWidth      = 32,
  parameter type                  reg_req_t      = idma_reg64_launcher_pkg::reg_req_t,
  parameter type                  reg_rsp_t      = idma_reg64_launcher_pkg::reg_rsp_t,
  parameter logic [AddrWidth-1:0] BaseAddr       = '0,
  parameter logic [AddrWidth-1:0] SrcAddrOffset  = 'h00,
  parameter logic [AddrWidth-1:0] DstAddrOffset  = 'h08,
  parameter logic [AddrWidth-1:0] NumBytesOffset = 'h10,
  parameter logic [AddrWidth-1:0] ConfOffset     = 'h18,
  parameter logic [AddrWidth-1:0] NextIdOffset   = 'h28,
  parameter logic [AddrWidth-1:0] DoneOffset     = 'h30,
  parameter int unsigned          PollGap        = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [63:0] job_src_i,
  input  logic [63:0] job_dst_i,
  input  logic [63:0] job_len_i,
  input  logic        job_decouple_i,
  input  logic        job_deburst_i,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  output logic        cpl_valid_o,
  input  logic        cpl_ready_i,
  output logic [63:0] cpl_id_o,
  output logic        cpl_error_o,
  output logic        busy_o
);

  localparam int unsigned CntWidth = (PollGap > 1) ? $clog2(PollGap) : 1;

  typedef enum logic [3:0] {
    StIdle, StWrSrc, StWrDst, StWrLen, StWrConf, StRdNext, StWait, StRdDone, StCpl
  } state_e;

  state_e               state_q, state_d;
  reg_req_t             req_q, req_d;
  logic [63:0]          src_q, src_d, dst_q, dst_d, len_q, len_d, id_q, id_d;
  logic [1:0]           conf_q, conf_d;
  logic                 err_q, err_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic                 bus_write;
  logic [AddrWidth-1:0] bus_addr;
  logic [63:0]          bus_wdata;
  logic                 retired;

  // Wrap-safe: the transfer has retired when (done - id) is non-negative as a signed value.
  assign retired = (reg_rsp_i.rdata - id_q) < 64'h8000_0000_0000_0000;

  always_comb begin
    bus_write = 1'b1;
    bus_addr  = BaseAddr + SrcAddrOffset;
    bus_wdata = src_q;
    unique case (state_q)
      StWrDst: begin
        bus_addr  = BaseAddr + DstAddrOffset;
        bus_wdata = dst_q;
      end
      StWrLen: begin
        bus_addr  = BaseAddr + NumBytesOffset;
        bus_wdata = len_q;
      end
      StWrConf: begin
        bus_addr  = BaseAddr + ConfOffset;
        bus_wdata = {62'b0, conf_q};
      end
      StRdNext: begin
        bus_write = 1'b0;
        bus_addr  = BaseAddr + NextIdOffset;
        bus_wdata = '0;
      end
      StRdDone: begin
        bus_write = 1'b0;
        bus_addr  = BaseAddr + DoneOffset;
        bus_wdata = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    conf_d  = conf_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (job_valid_i) begin
          src_d  = job_src_i;
          dst_d  = job_dst_i;
          len_d  = job_len_i;
          conf_d = {job_deburst_i, job_decouple_i};
          id_d   = '0;
          cnt_d  = '0;
          // The DMA refuses zero-length launches, so report failure without touching the bus.
          if (job_len_i == '0) begin
            err_d   = 1'b1;
            state_d = StCpl;
          end else begin
            err_d   = 1'b0;
            state_d = StWrSrc;
          end
        end
      end

      StWait: begin
        if (32'(cnt_q) == PollGap - 1) begin
          cnt_d   = '0;
          state_d = StRdDone;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StCpl: begin
        if (cpl_ready_i) state_d = StIdle;
      end

      default: begin
        if (!req_q.valid) begin
          req_d.valid = 1'b1;
          req_d.write = bus_write;
          req_d.addr  = bus_addr;
          req_d.wdata = bus_wdata;
          if (bus_write) req_d.wstrb = '1;
          else           req_d.wstrb = '0;
        end else if (reg_rsp_i.ready) begin
          req_d.valid = 1'b0;
          if (reg_rsp_i.error) begin
            err_d   = 1'b1;
            state_d = StCpl;
          end else begin
            unique case (state_q)
              StWrSrc:  state_d = StWrDst;
              StWrDst:  state_d = StWrLen;
              StWrLen:  state_d = StWrConf;
              StWrConf: state_d = StRdNext;
              StRdNext: begin
                // ID 0 means the frontend rejected the launch.
                if (reg_rsp_i.rdata == '0) begin
                  err_d   = 1'b1;
                  state_d = StCpl;
                end else begin
                  id_d    = reg_rsp_i.rdata;
                  state_d = StRdDone;
                end
              end
              StRdDone: begin
                if (retired)           state_d = StCpl;
                else if (PollGap == 0) req_d.valid = 1'b1;
                else                   state_d = StWait;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      conf_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      conf_q  <= conf_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_req_o   = req_q;
  assign job_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign cpl_valid_o = (state_q == StCpl);
  assign cpl_id_o    = cpl_valid_o ? id_q : '0;
  assign cpl_error_o = cpl_valid_o & err_q;

endmodule
